round_sequencer: RTL and testbench
==================================

# round_sequencer

Round controller for the higher-or-lower game. It turns debounced button pulses into game rounds. It owns the random draw, guess evaluation, score and round counters, and the timed reveal. It sits between the button_pulse instances and the VGA/LED output logic. Its `state` output drives the VGA scene select and the RGB LED directly.

## Interface
Parameters:
- `REVEAL_CYCLES`, default 200_000_000: clocks the drawn card is shown before the round resolves (2 s at 100 MHz); must be ≥ 2.
- `MAX_ROUNDS`, default 10: consecutive correct guesses that end the game as a win; range 1..255.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk`, input, 1: system clock (100 MHz).
- `reset`, input, 1: synchronous, active-low reset.
- `higher_pulse`, input, 1: one-cycle "higher" guess pulse.
- `lower_pulse`, input, 1: one-cycle "lower" guess pulse.
- `confirm_pulse`, input, 1: one-cycle start/acknowledge pulse.
- `state`, output, 3: current FSM state code.
- `cur_num`, output, 4: card on display.
- `next_num`, output, 4: drawn card; valid only while `reveal` = 1.
- `reveal`, output, 1: high in REVEAL, OVER and DONE.
- `score`, output, 8: correct guesses this game.
- `round`, output, 8: rounds completed this game.
- `rgb_led`, output, 3: {r,g,b} status LED.

## Operation
- **LFSR**
  - 16-bit Fibonacci LFSR with taps 16,14,13,11, shifted every cycle in every state.
  - Set to `LFSR_SEED` on reset; never reaches zero.
  - A "draw" samples `lfsr[3:0]`.
- **State codes:** IDLE=0, DEAL=1, GUESS=2, REVEAL=3, OVER=5, DONE=6. Codes 4 and 7 are unused; if either is entered, the next state is IDLE.
- **IDLE**
  - `score`, `round`, `cur_num` and `next_num` are held at 0.
  - `confirm_pulse` moves to DEAL.
- **DEAL** (exactly 1 cycle)
  - `cur_num` ← draw.
  - Next state is GUESS.
- **GUESS**
  - `higher_pulse` alone: latch guess=H, `next_num` ← draw, go to REVEAL.
  - `lower_pulse` alone: latch guess=L, `next_num` ← draw, go to REVEAL.
  - Both pulses high in the same cycle: ignored, stay in GUESS.
  - `confirm_pulse`: ignored.
- **REVEAL**
  - On entry, `correct` is registered as (H and `next_num` > `cur_num`) or (L and `next_num` < `cur_num`). Equal cards are a loss. The comparison is unsigned, 4-bit.
  - The timer runs for `REVEAL_CYCLES` cycles. All buttons are ignored while it runs.
  - At timer expiry, if `correct`:
    - `score` += 1 and `round` += 1; both saturate at 255.
    - If the new `round` == `MAX_ROUNDS`, go to DONE.
    - Otherwise `cur_num` ← `next_num` and go to GUESS.
  - At timer expiry, if not `correct`: go to OVER. `score` and `round` are unchanged.
- **OVER / DONE**
  - All outputs hold, including `cur_num` and `next_num`.
  - `confirm_pulse` moves to IDLE; the counters clear on the IDLE entry edge.
- **`rgb_led` by state**
  - IDLE and DEAL: 000.
  - GUESS: 001.
  - REVEAL: 010 if `correct`, else 100.
  - OVER: 100.
  - DONE: 010.
- **Reset**
  - `reset` = 0 at any clock edge, in any state (including mid-REVEAL), forces IDLE.
  - Reset clears all outputs to 0, `state` to 0 and the timer to 0, and loads `LFSR_SEED`.

## Timing
- All outputs are registered; none is combinational from an input.
- Input pulse at edge N gives the state change visible after edge N.
- confirm in IDLE at edge N:
  - DEAL after edge N.
  - GUESS and `cur_num` valid after edge N+1.
- Guess accepted at edge N:
  - REVEAL, `next_num`, `reveal` and `rgb_led` valid after edge N.
  - Resolution at edge N+`REVEAL_CYCLES`: REVEAL lasts exactly `REVEAL_CYCLES` cycles.
- The timer is `$clog2(REVEAL_CYCLES)` bits, cleared on REVEAL entry.
- A pulse arriving on the resolving edge is ignored; pulses are not queued.
- `reveal` drops on the same edge GUESS is re-entered.

## Test plan
Bench settings: `REVEAL_CYCLES`=4, `MAX_ROUNDS`=3. Expected draws come from a bench LFSR model seeded 16'hACE1.
1. **Reset:** hold `reset`=0 for 3 cycles, then release.
   - All outputs 0, `state`=0, `rgb_led`=000.
   - LFSR matches the model (first value 16'hACE1).
2. **Start:** pulse confirm.
   - `state` 0→1→2 on consecutive edges.
   - `cur_num` = model `lfsr[3:0]` at the DEAL edge; `rgb_led`=001.
3. **Correct round:** guess in the direction that the model predicts correct.
   - REVEAL lasts exactly 4 cycles with `rgb_led`=010.
   - Then `score`=1, `round`=1, `cur_num` = previous `next_num`, `state`=2.
4. **Win:** three correct rounds in a row.
   - `state`=6, `score`=3, `round`=3, `rgb_led`=010.
   - confirm returns to IDLE with `score`=0.
5. **Loss and tie:** force `next_num` == `cur_num` by timing the guess from the model, guessing H.
   - REVEAL shows `rgb_led`=100, then `state`=5 with `score` unchanged.
   - confirm returns to `state`=0.
6. **Edge cases:**
   - Higher and lower pulsed in the same cycle in GUESS: state stays 2.
   - `reset`=0 at cycle 2 of REVEAL: IDLE and all-zero outputs on the next edge.
   - Buttons pulsed during REVEAL: no effect.

Source files
------------

// File: rtl/round_sequencer.sv
// Round controller for the higher-or-lower game: draws cards from a free-running
// LFSR, evaluates guesses, keeps score/round counts and times the card reveal.
module round_sequencer #(
  parameter int          REVEAL_CYCLES = 200_000_000,
  parameter int          MAX_ROUNDS    = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       higher_pulse,
  input  logic       lower_pulse,
  input  logic       confirm_pulse,
  output logic [2:0] state,
  output logic [3:0] cur_num,
  output logic [3:0] next_num,
  output logic       reveal,
  output logic [7:0] score,
  output logic [7:0] round,
  output logic [2:0] rgb_led
);

  localparam int TW = $clog2(REVEAL_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(REVEAL_CYCLES - 1);
  localparam logic [7:0]    ROUND_WIN  = 8'(MAX_ROUNDS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DEAL   = 3'd1,
    GUESS  = 3'd2,
    REVEAL = 3'd3,
    OVER   = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic [3:0]    draw;
  logic [TW-1:0] timer, timer_d;
  logic          guess_h, guess_d;
  logic          correct, correct_d;
  logic [3:0]    cur_d, next_d;
  logic [7:0]    score_d, round_d;
  logic          reveal_d;
  logic [2:0]    rgb_d;

  // Counters stop at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // LED colour follows the state the FSM is about to enter.
  function automatic logic [2:0] led_for(input state_t s, input logic c);
    case (s)
      GUESS:   return 3'b001;
      REVEAL:  return c ? 3'b010 : 3'b100;
      OVER:    return 3'b100;
      DONE:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign draw    = lfsr[3:0];
  assign state   = state_q;

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer;
    guess_d   = guess_h;
    correct_d = correct;
    cur_d     = cur_num;
    next_d    = next_num;
    score_d   = score;
    round_d   = round;
    case (state_q)
      IDLE: begin
        cur_d     = 4'd0;
        next_d    = 4'd0;
        score_d   = 8'd0;
        round_d   = 8'd0;
        correct_d = 1'b0;
        if (confirm_pulse) state_d = DEAL;
      end
      DEAL: begin
        cur_d   = draw;
        state_d = GUESS;
      end
      GUESS: begin
        // Exactly one direction button; a simultaneous pair is ambiguous.
        if (higher_pulse ^ lower_pulse) begin
          guess_d   = higher_pulse;
          next_d    = draw;
          timer_d   = '0;
          correct_d = higher_pulse ? (draw > cur_num) : (draw < cur_num);
          state_d   = REVEAL;
        end
      end
      REVEAL: begin
        if (timer == TIMER_LAST) begin
          if (correct) begin
            score_d = sat_inc(score);
            round_d = sat_inc(round);
            if (round_d == ROUND_WIN) begin
              state_d = DONE;
            end else begin
              cur_d   = next_num;
              state_d = GUESS;
            end
          end else begin
            state_d = OVER;
          end
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      OVER, DONE: begin
        if (confirm_pulse) begin
          state_d   = IDLE;
          cur_d     = 4'd0;
          next_d    = 4'd0;
          score_d   = 8'd0;
          round_d   = 8'd0;
          correct_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        cur_d     = 4'd0;
        next_d    = 4'd0;
        score_d   = 8'd0;
        round_d   = 8'd0;
        correct_d = 1'b0;
      end
    endcase
    reveal_d = (state_d == REVEAL) || (state_d == OVER) || (state_d == DONE);
    rgb_d    = led_for(state_d, correct_d);
  end

  // State, LFSR, timer and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      lfsr     <= LFSR_SEED;
      timer    <= '0;
      guess_h  <= 1'b0;
      correct  <= 1'b0;
      cur_num  <= 4'd0;
      next_num <= 4'd0;
      score    <= 8'd0;
      round    <= 8'd0;
      reveal   <= 1'b0;
      rgb_led  <= 3'b000;
    end else begin
      state_q  <= state_d;
      lfsr     <= {lfsr[14:0], lfsr_fb};
      timer    <= timer_d;
      guess_h  <= guess_d;
      correct  <= correct_d;
      cur_num  <= cur_d;
      next_num <= next_d;
      score    <= score_d;
      round    <= round_d;
      reveal   <= reveal_d;
      rgb_led  <= rgb_d;
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with a reference LFSR predicting every draw.
module tb_round_sequencer;

  localparam int          RC   = 4;
  localparam int          MR   = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       higher_pulse = 1'b0;
  logic       lower_pulse = 1'b0;
  logic       confirm_pulse = 1'b0;
  logic [2:0] state;
  logic [3:0] cur_num;
  logic [3:0] next_num;
  logic       reveal;
  logic [7:0] score;
  logic [7:0] round;
  logic [2:0] rgb_led;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr = SEED;
  logic [15:0] pre;
  logic [3:0]  exp_cur;
  logic [3:0]  d;
  int          exp_score;

  round_sequencer #(.REVEAL_CYCLES(RC), .MAX_ROUNDS(MR), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .higher_pulse(higher_pulse), .lower_pulse(lower_pulse),
    .confirm_pulse(confirm_pulse), .state(state), .cur_num(cur_num), .next_num(next_num),
    .reveal(reveal), .score(score), .round(round), .rgb_led(rgb_led)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Taps 16,14,13,11 expressed as a mask over bits 15,13,12,10.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic fb;
    fb = ^(v & 16'hB400);
    return (v << 1) | {15'd0, fb};
  endfunction

  // One clock edge; pre holds the LFSR value the DUT sampled at that edge.
  task automatic step();
    pre = m_lfsr;
    @(posedge clk);
    if (!reset) m_lfsr = SEED;
    else        m_lfsr = lfsr_next(pre);
    #1;
  endtask

  task automatic start_game();
    confirm_pulse = 1'b1;
    step();
    confirm_pulse = 1'b0;
    check_eq("start_deal", state, 1);
    step();
    exp_cur = pre[3:0];
    check_eq("start_guess", state, 2);
    check_eq("start_cur", cur_num, exp_cur);
    check_eq("start_rgb", rgb_led, 3'b001);
  endtask

  // Waits until the upcoming draw differs from the card shown, then guesses right.
  task automatic guess_correct();
    int bound = 0;
    while (m_lfsr[3:0] == exp_cur && bound < 200) begin
      step();
      bound++;
    end
    check_eq("wait_diff", bound < 200, 1);
    d = m_lfsr[3:0];
    if (d > exp_cur) higher_pulse = 1'b1;
    else             lower_pulse = 1'b1;
    step();
    higher_pulse = 1'b0;
    lower_pulse  = 1'b0;
    check_eq("rev_state", state, 3);
    check_eq("rev_next", next_num, d);
    check_eq("rev_reveal", reveal, 1);
    check_eq("rev_rgb", rgb_led, 3'b010);
  endtask

  task automatic play_correct_round(input bool_last);
    guess_correct();
    for (int k = 1; k < RC; k++) begin
      // Buttons during the reveal must have no effect.
      if (k == 1) higher_pulse = 1'b1;
      if (k == 2) confirm_pulse = 1'b1;
      if (k == 3) lower_pulse = 1'b1;
      step();
      higher_pulse  = 1'b0;
      lower_pulse   = 1'b0;
      confirm_pulse = 1'b0;
      check_eq("rev_hold", state, 3);
      check_eq("rev_hold_rgb", rgb_led, 3'b010);
    end
    // Lower pulse on the resolving edge is ignored.
    lower_pulse = 1'b1;
    step();
    lower_pulse = 1'b0;
    exp_score++;
    check_eq("res_score", score, exp_score);
    check_eq("res_round", round, exp_score);
    if (bool_last) begin
      check_eq("win_state", state, 6);
      check_eq("win_rgb", rgb_led, 3'b010);
      check_eq("win_reveal", reveal, 1);
      check_eq("win_next", next_num, d);
    end else begin
      check_eq("res_state", state, 2);
      check_eq("res_cur", cur_num, d);
      check_eq("res_reveal", reveal, 0);
      check_eq("res_rgb", rgb_led, 3'b001);
      exp_cur = d;
      step();
      check_eq("res_no_queue", state, 2);
    end
  endtask

  initial begin
    int bound;
    // Reset held low for three edges.
    reset = 1'b0;
    repeat (3) step();
    check_eq("rst_state", state, 0);
    check_eq("rst_cur", cur_num, 0);
    check_eq("rst_next", next_num, 0);
    check_eq("rst_reveal", reveal, 0);
    check_eq("rst_score", score, 0);
    check_eq("rst_round", round, 0);
    check_eq("rst_rgb", rgb_led, 0);
    check_eq("rst_lfsr", dut.lfsr, 16'hACE1);
    reset = 1'b1;

    // Full game: three correct rounds to a win.
    exp_score = 0;
    start_game();
    play_correct_round(1'b0);
    check_eq("lfsr_track", dut.lfsr, m_lfsr);
    // Both direction buttons together are ignored.
    higher_pulse = 1'b1;
    lower_pulse  = 1'b1;
    step();
    higher_pulse = 1'b0;
    lower_pulse  = 1'b0;
    check_eq("both_btn", state, 2);
    check_eq("both_btn_reveal", reveal, 0);
    play_correct_round(1'b0);
    play_correct_round(1'b1);
    step();
    check_eq("done_hold", state, 6);
    confirm_pulse = 1'b1;
    step();
    confirm_pulse = 1'b0;
    check_eq("win_idle", state, 0);
    check_eq("win_idle_score", score, 0);
    check_eq("win_idle_round", round, 0);
    check_eq("win_idle_cur", cur_num, 0);
    check_eq("win_idle_rgb", rgb_led, 0);

    // Tie: guess higher when the next draw equals the card shown.
    start_game();
    bound = 0;
    while (m_lfsr[3:0] != exp_cur && bound < 500) begin
      step();
      bound++;
    end
    check_eq("wait_tie", bound < 500, 1);
    higher_pulse = 1'b1;
    step();
    higher_pulse = 1'b0;
    check_eq("tie_state", state, 3);
    check_eq("tie_next", next_num, exp_cur);
    check_eq("tie_rgb", rgb_led, 3'b100);
    repeat (RC - 1) step();
    check_eq("tie_hold", state, 3);
    step();
    check_eq("over_state", state, 5);
    check_eq("over_score", score, 0);
    check_eq("over_round", round, 0);
    check_eq("over_rgb", rgb_led, 3'b100);
    check_eq("over_reveal", reveal, 1);
    check_eq("over_cur", cur_num, exp_cur);
    confirm_pulse = 1'b1;
    step();
    confirm_pulse = 1'b0;
    check_eq("over_idle", state, 0);

    // Reset asserted in the second cycle of a reveal.
    exp_score = 0;
    start_game();
    guess_correct();
    step();
    check_eq("mid_rev", state, 3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_eq("mid_rst_state", state, 0);
    check_eq("mid_rst_next", next_num, 0);
    check_eq("mid_rst_cur", cur_num, 0);
    check_eq("mid_rst_reveal", reveal, 0);
    check_eq("mid_rst_rgb", rgb_led, 0);
    check_eq("mid_rst_lfsr", dut.lfsr, SEED);
    check_eq("mid_rst_timer", dut.timer, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
